// File: rtl/flag_condition_unit.sv
// Purpose: holds the {N,Z,C,V} flag register and evaluates condition codes against it or against a direct operand.
// Latency: one cycle from request acceptance to a registered result on o_resp_taken / o_resp_valid.
// Backpressure: single-entry output buffer; o_req_ready = !o_resp_valid | i_resp_ready, and a held response stays stable.
module flag_condition_unit #(
    parameter int WIDTH  = 8,
    parameter int BYPASS = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,

    // Flag register update path
    input  logic             i_flags_we,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_carry,
    input  logic             i_alu_overflow,
    input  logic             i_flags_restore,
    input  logic [3:0]       i_flags_in,
    output logic [3:0]       o_flags_out,

    // Condition request channel
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [3:0]       i_req_op,
    input  logic             i_req_use_operand,
    input  logic [WIDTH-1:0] i_req_operand,

    // Condition response channel
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic             o_resp_taken
);

    // Bit positions inside the packed {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Condition code encoding.
    typedef enum logic [3:0] {
        CC_NEVER = 4'b0000,
        CC_EQ    = 4'b0001,
        CC_LT    = 4'b0010,
        CC_LE    = 4'b0011,
        CC_AL    = 4'b0100,
        CC_NE    = 4'b0101,
        CC_GT    = 4'b0110,
        CC_GE    = 4'b0111,
        CC_LO    = 4'b1000,
        CC_LS    = 4'b1001,
        CC_HI    = 4'b1010,
        CC_HS    = 4'b1011,
        CC_MI    = 4'b1100,
        CC_PL    = 4'b1101,
        CC_VS    = 4'b1110,
        CC_VC    = 4'b1111
    } cond_e;

    // Evaluate one condition code against a {N,Z,C,V} vector.
    function automatic logic f_eval_cond(input logic [3:0] op, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic lt;
        logic res;
        n   = flags[FLAG_N];
        z   = flags[FLAG_Z];
        c   = flags[FLAG_C];
        v   = flags[FLAG_V];
        lt  = n ^ v;
        res = 1'b0;
        case (cond_e'(op))
            CC_NEVER: res = 1'b0;
            CC_EQ:    res = z;
            CC_LT:    res = lt;
            CC_LE:    res = z | lt;
            CC_AL:    res = 1'b1;
            CC_NE:    res = ~z;
            CC_GT:    res = ~z & ~lt;
            CC_GE:    res = ~lt;
            CC_LO:    res = ~c;
            CC_LS:    res = ~c | z;
            CC_HI:    res = c & ~z;
            CC_HS:    res = c;
            CC_MI:    res = n;
            CC_PL:    res = ~n;
            CC_VS:    res = v;
            CC_VC:    res = ~v;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0] r_flags;
    logic       r_resp_vld;
    logic       r_resp_taken;

    // ------------------------------------------------------------------
    // Flag write path
    // ------------------------------------------------------------------
    logic [3:0] w_alu_flags;
    logic       w_flags_wr_en;
    logic [3:0] w_flags_wr_dat;

    // Flags the ALU would produce this cycle; result is treated as two's complement.
    always_comb begin
        w_alu_flags         = 4'b0000;
        w_alu_flags[FLAG_N] = i_alu_result[WIDTH-1];
        w_alu_flags[FLAG_Z] = (i_alu_result == '0);
        w_alu_flags[FLAG_C] = i_alu_carry;
        w_alu_flags[FLAG_V] = i_alu_overflow;
    end

    // Interrupt-return restore wins over a concurrent ALU write.
    always_comb begin
        w_flags_wr_en  = i_flags_restore | i_flags_we;
        w_flags_wr_dat = i_flags_restore ? i_flags_in : w_alu_flags;
    end

    // Flag register: load on write, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_flags_wr_en) begin
            r_flags <= w_flags_wr_dat;
        end
    end

    // ------------------------------------------------------------------
    // Evaluation path
    // ------------------------------------------------------------------
    logic [3:0] w_reg_view;
    logic [3:0] w_operand_flags;
    logic [3:0] w_eval_flags;
    logic       w_eval_taken;

    // Flag view seen by a register-mode request: with forwarding enabled the
    // value being written this cycle is visible, otherwise only the stored one.
    always_comb begin
        w_reg_view = r_flags;
        if ((BYPASS != 0) && w_flags_wr_en) begin
            w_reg_view = w_flags_wr_dat;
        end
    end

    // Direct-operand mode: Z/N from the operand itself, C and V forced clear,
    // so the signed comparisons reduce to comparisons against zero.
    always_comb begin
        w_operand_flags         = 4'b0000;
        w_operand_flags[FLAG_N] = i_req_operand[WIDTH-1];
        w_operand_flags[FLAG_Z] = (i_req_operand == '0);
    end

    // Pick the flag source for this request and evaluate the condition.
    always_comb begin
        w_eval_flags = i_req_use_operand ? w_operand_flags : w_reg_view;
        w_eval_taken = f_eval_cond(i_req_op, w_eval_flags);
    end

    // ------------------------------------------------------------------
    // Handshake and output buffer
    // ------------------------------------------------------------------
    logic w_req_ready;
    logic w_accept;

    // Buffer slot is free when empty or being drained this cycle.
    always_comb begin
        w_req_ready = ~r_resp_vld | i_resp_ready;
        w_accept    = i_req_valid & w_req_ready;
    end

    // Single-entry response buffer: load on accept, clear when drained with
    // nothing new behind it, otherwise hold result and valid stable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_resp_vld   <= 1'b0;
            r_resp_taken <= 1'b0;
        end else if (w_accept) begin
            r_resp_vld   <= 1'b1;
            r_resp_taken <= w_eval_taken;
        end else if (i_resp_ready) begin
            r_resp_vld   <= 1'b0;
        end
    end

    // Outputs
    assign o_flags_out  = r_flags;
    assign o_req_ready  = w_req_ready;
    assign o_resp_valid = r_resp_vld;
    assign o_resp_taken = r_resp_taken;

endmodule

// File: tb/tb_flag_condition_unit.sv
module tb_flag_condition_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         flags_we;
    logic [W-1:0] alu_result;
    logic         alu_carry;
    logic         alu_overflow;
    logic         flags_restore;
    logic [3:0]   flags_in;
    logic         req_valid;
    logic [3:0]   req_op;
    logic         req_use_operand;
    logic [W-1:0] req_operand;
    logic         resp_ready;

    logic [3:0]   flags_out_b1, flags_out_b0;
    logic         req_ready_b1, req_ready_b0;
    logic         resp_valid_b1, resp_valid_b0;
    logic         resp_taken_b1, resp_taken_b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: flags as a {N,Z,C,V} nibble, one buffered result per bypass flavour.
    logic [3:0] m_flags;
    bit         m_vld;
    bit         m_t1;
    bit         m_t0;

    flag_condition_unit #(.WIDTH(W), .BYPASS(1)) u_dut_b1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_flags_we(flags_we), .i_alu_result(alu_result), .i_alu_carry(alu_carry),
        .i_alu_overflow(alu_overflow), .i_flags_restore(flags_restore), .i_flags_in(flags_in),
        .o_flags_out(flags_out_b1),
        .i_req_valid(req_valid), .o_req_ready(req_ready_b1), .i_req_op(req_op),
        .i_req_use_operand(req_use_operand), .i_req_operand(req_operand),
        .o_resp_valid(resp_valid_b1), .i_resp_ready(resp_ready), .o_resp_taken(resp_taken_b1)
    );

    flag_condition_unit #(.WIDTH(W), .BYPASS(0)) u_dut_b0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_flags_we(flags_we), .i_alu_result(alu_result), .i_alu_carry(alu_carry),
        .i_alu_overflow(alu_overflow), .i_flags_restore(flags_restore), .i_flags_in(flags_in),
        .o_flags_out(flags_out_b0),
        .i_req_valid(req_valid), .o_req_ready(req_ready_b0), .i_req_op(req_op),
        .i_req_use_operand(req_use_operand), .i_req_operand(req_operand),
        .o_resp_valid(resp_valid_b0), .i_resp_ready(resp_ready), .o_resp_taken(resp_taken_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Condition meaning written from the flag semantics.
    function automatic bit cond(input logic [3:0] op, input logic [3:0] f);
        bit n, z, c, v, signed_lt;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        signed_lt = (n != v);
        case (op)
            4'd0:  return 1'b0;
            4'd1:  return z;
            4'd2:  return signed_lt;
            4'd3:  return z || signed_lt;
            4'd4:  return 1'b1;
            4'd5:  return !z;
            4'd6:  return !z && !signed_lt;
            4'd7:  return !signed_lt;
            4'd8:  return !c;
            4'd9:  return !c || z;
            4'd10: return c && !z;
            4'd11: return c;
            4'd12: return n;
            4'd13: return !n;
            4'd14: return v;
            default: return !v;
        endcase
    endfunction

    // Operand viewed as a signed number compared against zero.
    function automatic logic [3:0] operand_flags(input logic [W-1:0] x);
        int s;
        s = int'($signed(x));
        return {s < 0, s == 0, 1'b0, 1'b0};
    endfunction

    function automatic logic [3:0] alu_flags(input logic [W-1:0] r, input logic c, input logic v);
        int s;
        s = int'($signed(r));
        return {s < 0, s == 0, c, v};
    endfunction

    // Advance one clock and update the model from the inputs present before the edge.
    task automatic tick();
        bit         acc;
        logic [3:0] old_f, new_f, f1, f0;
        acc   = req_valid && (!m_vld || resp_ready);
        old_f = m_flags;
        if (flags_restore)  new_f = flags_in;
        else if (flags_we)  new_f = alu_flags(alu_result, alu_carry, alu_overflow);
        else                new_f = old_f;
        if (req_use_operand) begin
            f1 = operand_flags(req_operand);
            f0 = f1;
        end else begin
            f1 = new_f;
            f0 = old_f;
        end
        @(posedge clk);
        #1;
        m_flags = new_f;
        if (acc) begin
            m_vld = 1'b1;
            m_t1  = cond(req_op, f1);
            m_t0  = cond(req_op, f0);
        end else if (resp_ready) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, " flags_b1"}, 32'(flags_out_b1), 32'(m_flags));
        check({tag, " flags_b0"}, 32'(flags_out_b0), 32'(m_flags));
        check({tag, " valid_b1"}, 32'(resp_valid_b1), 32'(m_vld));
        check({tag, " valid_b0"}, 32'(resp_valid_b0), 32'(m_vld));
        check({tag, " taken_b1"}, 32'(resp_taken_b1), 32'(m_t1));
        check({tag, " taken_b0"}, 32'(resp_taken_b0), 32'(m_t0));
    endtask

    task automatic idle_inputs();
        flags_we = 0; alu_result = '0; alu_carry = 0; alu_overflow = 0;
        flags_restore = 0; flags_in = '0;
        req_valid = 0; req_op = '0; req_use_operand = 0; req_operand = '0;
        resp_ready = 1;
    endtask

    typedef struct {
        bit         we;
        logic [7:0] res;
        bit         c;
        bit         v;
        bit         rs;
        logic [3:0] fin;
        bit         uo;
        logic [7:0] opnd;
        logic [3:0] op;
        logic [3:0] exp_flags;
        bit         exp_t1;
        bit         exp_t0;
    } vec_t;

    vec_t tbl[24];

    initial begin
        tbl[0]  = '{1, 8'h00, 1, 0, 0, 4'b0000, 0, 8'h00, 4'b0001, 4'b0110, 1, 0};
        tbl[1]  = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b0001, 4'b0110, 1, 1};
        tbl[2]  = '{1, 8'h05, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b0001, 4'b0000, 0, 1};
        tbl[3]  = '{1, 8'h00, 1, 0, 1, 4'b1001, 0, 8'h00, 4'b1110, 4'b1001, 1, 0};
        tbl[4]  = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b0010, 4'b1001, 0, 0};
        tbl[5]  = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b1110, 4'b1001, 1, 1};
        tbl[6]  = '{0, 8'h00, 0, 0, 0, 4'b0000, 1, 8'h80, 4'b0010, 4'b1001, 1, 1};
        tbl[7]  = '{0, 8'h00, 0, 0, 0, 4'b0000, 1, 8'h80, 4'b0110, 4'b1001, 0, 0};
        tbl[8]  = '{0, 8'h00, 0, 0, 0, 4'b0000, 1, 8'h80, 4'b0111, 4'b1001, 0, 0};
        tbl[9]  = '{0, 8'h00, 0, 0, 0, 4'b0000, 1, 8'h00, 4'b0011, 4'b1001, 1, 1};
        tbl[10] = '{1, 8'h80, 0, 0, 0, 4'b0000, 1, 8'h00, 4'b1110, 4'b1000, 0, 0};
        tbl[11] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b1000, 4'b1000, 1, 1};
        tbl[12] = '{1, 8'hFF, 1, 0, 0, 4'b0000, 0, 8'h00, 4'b1010, 4'b1010, 1, 0};
        tbl[13] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b1001, 4'b1010, 0, 0};
        tbl[14] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b0100, 4'b1010, 1, 1};
        tbl[15] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b0000, 4'b1010, 0, 0};
        tbl[16] = '{1, 8'h00, 0, 1, 0, 4'b0000, 0, 8'h00, 4'b0011, 4'b0101, 1, 1};
        tbl[17] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b0101, 4'b0101, 0, 0};
        tbl[18] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b1101, 4'b0101, 1, 1};
        tbl[19] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b1111, 4'b0101, 0, 0};
        tbl[20] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b1011, 4'b0101, 0, 0};
        tbl[21] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b1100, 4'b0101, 0, 0};
        tbl[22] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b0111, 4'b0101, 0, 0};
        tbl[23] = '{0, 8'h00, 0, 0, 0, 4'b0000, 0, 8'h00, 4'b0010, 4'b0101, 1, 1};

        // Reset state
        rst_n = 0;
        idle_inputs();
        m_flags = '0; m_vld = 0; m_t1 = 0; m_t0 = 0;
        #1;
        check("reset flags_b1", 32'(flags_out_b1), 0);
        check("reset valid_b1", 32'(resp_valid_b1), 0);
        check("reset taken_b1", 32'(resp_taken_b1), 0);
        check("reset ready_b1", 32'(req_ready_b1), 1);
        check("reset valid_b0", 32'(resp_valid_b0), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // Directed table, one accepted request per cycle
        for (int i = 0; i < 24; i++) begin
            flags_we = tbl[i].we; alu_result = tbl[i].res; alu_carry = tbl[i].c;
            alu_overflow = tbl[i].v; flags_restore = tbl[i].rs; flags_in = tbl[i].fin;
            req_use_operand = tbl[i].uo; req_operand = tbl[i].opnd; req_op = tbl[i].op;
            req_valid = 1; resp_ready = 1;
            tick();
            check($sformatf("row%0d flags_b1", i), 32'(flags_out_b1), 32'(tbl[i].exp_flags));
            check($sformatf("row%0d flags_b0", i), 32'(flags_out_b0), 32'(tbl[i].exp_flags));
            check($sformatf("row%0d valid", i), 32'(resp_valid_b1), 1);
            check($sformatf("row%0d taken_b1", i), 32'(resp_taken_b1), 32'(tbl[i].exp_t1));
            check($sformatf("row%0d taken_b0", i), 32'(resp_taken_b0), 32'(tbl[i].exp_t0));
        end
        idle_inputs();

        // Consumer stalls 3 cycles: buffer holds, no acceptance
        req_valid = 1; req_op = 4'b0000; resp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d ready_b1", i), 32'(req_ready_b1), 0);
            check($sformatf("stall%0d ready_b0", i), 32'(req_ready_b0), 0);
            tick();
            check($sformatf("stall%0d valid", i), 32'(resp_valid_b1), 1);
            check($sformatf("stall%0d taken_b1", i), 32'(resp_taken_b1), 1);
            check($sformatf("stall%0d taken_b0", i), 32'(resp_taken_b0), 1);
        end

        // Streaming: one response per cycle
        resp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            req_op = (i % 2 == 0) ? 4'b0000 : 4'b0100;
            #1;
            check($sformatf("stream%0d ready", i), 32'(req_ready_b1), 1);
            tick();
            check($sformatf("stream%0d valid", i), 32'(resp_valid_b1), 1);
            check($sformatf("stream%0d taken_b1", i), 32'(resp_taken_b1), 32'(i % 2));
            check($sformatf("stream%0d taken_b0", i), 32'(resp_taken_b0), 32'(i % 2));
        end

        // Drain with no new request
        req_valid = 0;
        tick();
        check("drain valid_b1", 32'(resp_valid_b1), 0);
        check("drain valid_b0", 32'(resp_valid_b0), 0);
        resp_ready = 0;
        #1;
        check("empty ready_b1", 32'(req_ready_b1), 1);

        // Asynchronous reset mid-transaction
        req_valid = 1; req_op = 4'b0100;
        tick();
        check("pre-rst valid", 32'(resp_valid_b1), 1);
        check("pre-rst flags", 32'(flags_out_b1), 32'(4'b0101));
        #2;
        rst_n = 0;
        #1;
        check("arst valid_b1", 32'(resp_valid_b1), 0);
        check("arst valid_b0", 32'(resp_valid_b0), 0);
        check("arst flags_b1", 32'(flags_out_b1), 0);
        check("arst flags_b0", 32'(flags_out_b0), 0);
        check("arst taken_b1", 32'(resp_taken_b1), 0);
        check("arst ready_b1", 32'(req_ready_b1), 1);
        @(posedge clk);
        #1;
        check("arst held valid", 32'(resp_valid_b1), 0);
        idle_inputs();
        rst_n = 1;
        m_flags = '0; m_vld = 0; m_t1 = 0; m_t0 = 0;
        #1;
        check("post-rst ready", 32'(req_ready_b1), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            flags_we        = ($urandom_range(0, 2) == 0);
            flags_restore   = ($urandom_range(0, 5) == 0);
            flags_in        = 4'($urandom);
            alu_result      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            alu_carry       = 1'($urandom);
            alu_overflow    = 1'($urandom);
            req_valid       = ($urandom_range(0, 3) != 0);
            req_op          = 4'($urandom);
            req_use_operand = ($urandom_range(0, 3) == 0);
            req_operand     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            resp_ready      = ($urandom_range(0, 3) != 0);
            #1;
            check($sformatf("rnd%0d ready_b1", i), 32'(req_ready_b1), 32'(!m_vld || resp_ready));
            check($sformatf("rnd%0d ready_b0", i), 32'(req_ready_b0), 32'(!m_vld || resp_ready));
            tick();
            compare_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flag_condition_unit.md
FLAG_CONDITION_UNIT -- requirements
Module: flag_condition_unit

Interface
REQ-001 Parameter WIDTH, default 8: data/operand width in bits; legal range 4..32.
REQ-002 Parameter BYPASS, default 1: 1 = same-cycle flag write is forwarded to the evaluation; 0 = evaluation uses the registered flags only.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flags_we  input  1  load the flag register from the ALU this cycle.
REQ-006 alu_result  input  WIDTH  ALU result, used to derive Z and N.
REQ-007 alu_carry  input  1  ALU carry-out (C).
REQ-008 alu_overflow  input  1  ALU signed overflow (V).
REQ-009 flags_restore  input  1  load the flag register directly from flags_in (interrupt return).
REQ-010 flags_in  input  4  restore value {N,Z,C,V}.
REQ-011 flags_out  output  4  current registered flags {N,Z,C,V}.
REQ-012 req_valid  input  1  condition request present.
REQ-013 req_ready  output  1  unit can accept a request.
REQ-014 req_op  input  4  condition code per REQ-020.
REQ-015 req_use_operand  input  1  1 = evaluate against req_operand instead of the flags (direct-operand mode).
REQ-016 req_operand  input  WIDTH  signed operand for direct-operand mode.
REQ-017 resp_valid  output  1  result held on resp_taken.
REQ-018 resp_ready  input  1  consumer accepts the response.
REQ-019 resp_taken  output  1  condition result.

Function
REQ-020 Condition codes: 0000 never; 0001 Z; 0010 N^V (signed lt); 0011 Z|(N^V) (signed le); 0100 always; 0101 !Z; 0110 !Z&!(N^V) (signed gt); 0111 !(N^V) (signed ge); 1000 !C (unsigned lo); 1001 !C|Z (unsigned ls); 1010 C&!Z (unsigned hi); 1011 C (unsigned hs); 1100 N; 1101 !N; 1110 V; 1111 !V.
REQ-021 Flag derivation on flags_we: Z = (alu_result == 0); N = alu_result[WIDTH-1]; C = alu_carry; V = alu_overflow.
REQ-022 Priority when both are asserted: flags_restore over flags_we.
REQ-023 Flag register holds its value when neither flags_we nor flags_restore is asserted.
REQ-024 Direct-operand mode evaluates with Z = (req_operand == 0), N = req_operand[WIDTH-1], C = 0, V = 0; the flag register is neither read nor modified.
REQ-025 BYPASS=1: a request accepted in a cycle with flags_we or flags_restore evaluates against the value being written that cycle.
REQ-026 BYPASS=0: a request accepted in such a cycle evaluates against the pre-write register value.
REQ-027 Request accepted when req_valid & req_ready; result is registered; resp_valid rises exactly 1 cycle after acceptance (latency 1).
REQ-028 Single-entry output buffer: req_ready = !resp_valid | resp_ready (combinational).
REQ-029 resp_valid & !resp_ready: resp_taken and resp_valid hold stable; no new request is accepted.
REQ-030 Response consumed and new request accepted in the same cycle: resp_valid stays 1 and resp_taken updates to the new result (back-to-back, one result per cycle).
REQ-031 Response consumed with no new request: resp_valid falls to 0 next cycle.
REQ-032 Comparisons are two's-complement; no width extension; operand sign bit is bit WIDTH-1.

Reset
REQ-033 rst_n low asynchronously clears flags_out to 4'b0000, resp_valid to 0 and resp_taken to 0.
REQ-034 Reset mid-transaction discards any pending response; req_ready = 1 while in reset and after release.
REQ-035 Normal operation resumes on the first rising clk edge after rst_n deasserts.

Verification
REQ-036 WIDTH=8: flags_we, alu_result=8'h00, C=1, V=0; then request op 0001 -> flags_out=4'b0110, resp_taken=1 one cycle after acceptance.
REQ-037 Direct-operand, WIDTH=8: operand 8'h80 with ops 0010/0110/0111 -> taken 1/0/0; operand 8'h00 with op 0011 -> 1.
REQ-038 Same-cycle flags_we (result 8'h05) and request op 0001, with prior Z=1 -> taken 0 for BYPASS=1, taken 1 for BYPASS=0.
REQ-039 resp_ready held low 3 cycles with resp_valid=1 -> req_ready=0 and resp_taken stable; resp_ready then held high with continuous requests -> one response per cycle.
REQ-040 flags_restore=1 with flags_in=4'b1001 and flags_we=1 in the same cycle -> flags_out=4'b1001; requests op 1110 and op 0010 -> taken 1 and taken 0.
REQ-041 rst_n asserted while resp_valid=1, held asynchronously mid-cycle -> resp_valid=0 and flags_out=0 immediately, before the next clk edge.
